fizzbuzz_ascii_tx: RTL

Downstream formatter for the fizzbuzz sequencer: it accepts one result per cycle (fizz flag, buzz flag, number) and emits a byte stream with a valid/ready handshake. Each result becomes one line: "Fizz", "Buzz", "FizzBuzz" or the decimal number, followed by a line terminator. A small FIFO absorbs the per-cycle input rate while the serializer drains it one byte per accepted handshake.

---
 rtl/fizzbuzz_ascii_tx_if.sv | 33 +++
 rtl/fizzbuzz_ascii_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fizzbuzz_ascii_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : fizzbuzz_ascii_tx_if
// Description : Bundle of the fizzbuzz result input, the ASCII byte stream
//               (valid/ready) and the status flags of fizzbuzz_ascii_tx.
//               The slave modport is the formatter's view; master is the view
//               of the block that feeds results and sinks bytes.
// Revision    : 1.0 - initial release
// ============================================================================
interface fizzbuzz_ascii_tx_if #(
  parameter int G_NUM_W = 6
);
  logic               i_valid;
  logic               i_is_fizz;
  logic               i_is_buzz;
  logic [G_NUM_W-1:0] i_number;
  logic [7:0]         o_data;
  logic               o_valid;
  logic               i_ready;
  logic               o_busy;
  logic               o_overflow;

  modport master (
    output i_valid, i_is_fizz, i_is_buzz, i_number, i_ready,
    input  o_data, o_valid, o_busy, o_overflow
  );

  modport slave (
    input  i_valid, i_is_fizz, i_is_buzz, i_number, i_ready,
    output o_data, o_valid, o_busy, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/fizzbuzz_ascii_tx.sv
`default_nettype none
// ============================================================================
// Module      : fizzbuzz_ascii_tx
// Description : Formats fizzbuzz results into ASCII lines ("Fizz", "Buzz",
//               "FizzBuzz" or a decimal number, then a line terminator) on a
//               valid/ready byte stream. A small FIFO absorbs the input rate.
//               Optional feature macro: FIZZBUZZ_TX_CRLF_EN (terminator becomes
//               CR LF instead of LF).
//               G_NUM_W must match the G_NUM_W of the connected interface.
// Revision    : 1.0 - initial release
// ============================================================================
module fizzbuzz_ascii_tx #(
  parameter int G_NUM_W = 6,
  parameter int G_DEPTH = 4
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst,
  fizzbuzz_ascii_tx_if.slave bus
);

  localparam int AW    = $clog2(G_DEPTH);
  localparam int ENT_W = G_NUM_W + 2;
  localparam int REM_W = G_NUM_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_EOL  = 2'd3;

`ifdef FIZZBUZZ_TX_CRLF_EN
  localparam logic [2:0] C_EOL_LAST = 3'd1;
`else
  localparam logic [2:0] C_EOL_LAST = 3'd0;
`endif

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [ENT_W-1:0] mem_q [G_DEPTH];
  logic [ENT_W-1:0] mem_d [G_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;

  // Serializer state and working registers
  logic [1:0]       state_q, state_d;
  logic             fizz_q, fizz_d;
  logic             buzz_q, buzz_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [3:0]       hund_q, hund_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [2:0]       idx_q, idx_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;
  logic             is_number;
  logic [2:0]       emit_last;
  logic             conv_ge100;
  logic             conv_ge10;
  logic             fire;
  logic             valid_out;
  logic [7:0]       data_out;
  logic [3:0]       digit;
  logic             use_fizz;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO
  // is dropped even if the serializer frees a slot in that cycle.
  assign push       = bus.i_valid && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  assign is_number  = !fizz_q && !buzz_q;
  assign emit_last  = is_number ? 3'd2 : ((fizz_q && buzz_q) ? 3'd7 : 3'd3);
  // Compare in a 32-bit domain so narrow remainders never truncate 100.
  assign conv_ge100 = 32'(rem_q) >= 32'd100;
  assign conv_ge10  = 32'(rem_q) >= 32'd10;
  assign fire       = valid_out && bus.i_ready;

  assign bus.o_valid    = valid_out;
  assign bus.o_data     = data_out;
  assign bus.o_busy     = !fifo_empty || (state_q != S_IDLE);
  assign bus.o_overflow = overflow_q;

  // FIFO write, pointer advance and sticky overflow flag
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (bus.i_valid & fifo_full);
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {bus.i_is_fizz, bus.i_is_buzz, bus.i_number};
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // FIFO payload storage; contents are only meaningful between the pointers
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // FIFO pointers and overflow flag; reset discards buffered results
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Serializer state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Serializer next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = (head[ENT_W-1] || head[ENT_W-2]) ? S_EMIT : S_CONV;
        end
      end
      S_CONV: begin
        if (!conv_ge100 && !conv_ge10) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (fire && (idx_q == emit_last)) begin
          state_d = S_EOL;
        end
      end
      default: begin
        if (fire && (idx_q == C_EOL_LAST)) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Working registers: load on pop, decimal conversion, byte index stepping
  always_comb begin
    fizz_d = fizz_q;
    buzz_d = buzz_q;
    rem_d  = rem_q;
    hund_d = hund_q;
    tens_d = tens_q;
    ones_d = ones_q;
    idx_d  = idx_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          fizz_d = head[ENT_W-1];
          buzz_d = head[ENT_W-2];
          rem_d  = {1'b0, head[G_NUM_W-1:0]};
          hund_d = 4'd0;
          tens_d = 4'd0;
          ones_d = 4'd0;
          idx_d  = 3'd0;
        end
      end
      S_CONV: begin
        if (conv_ge100) begin
          rem_d  = rem_q - REM_W'(100);
          hund_d = hund_q + 4'd1;
        end else if (conv_ge10) begin
          rem_d  = rem_q - REM_W'(10);
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = 4'(rem_q);
          // Start at the most significant non-zero digit; ones always emits.
          idx_d  = (hund_q != 4'd0) ? 3'd0 : ((tens_q != 4'd0) ? 3'd1 : 3'd2);
        end
      end
      S_EMIT: begin
        if (fire) begin
          idx_d = (idx_q == emit_last) ? 3'd0 : idx_q + 3'd1;
        end
      end
      default: begin
        if (fire) begin
          idx_d = idx_q + 3'd1;
        end
      end
    endcase
  end

  // Working register flops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fizz_q <= 1'b0;
      buzz_q <= 1'b0;
      rem_q  <= '0;
      hund_q <= 4'd0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      idx_q  <= 3'd0;
    end else begin
      fizz_q <= fizz_d;
      buzz_q <= buzz_d;
      rem_q  <= rem_d;
      hund_q <= hund_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      idx_q  <= idx_d;
    end
  end

  // Output byte selection; driven only from registers so it holds under stall
  always_comb begin
    valid_out = 1'b0;
    data_out  = 8'h00;
    digit     = ones_q;
    use_fizz  = fizz_q && !(buzz_q && idx_q[2]);
    case (state_q)
      S_EMIT: begin
        valid_out = 1'b1;
        if (is_number) begin
          case (idx_q)
            3'd0:    digit = hund_q;
            3'd1:    digit = tens_q;
            default: digit = ones_q;
          endcase
          data_out = 8'h30 + {4'h0, digit};
        end else begin
          case (idx_q[1:0])
            2'd0:    data_out = use_fizz ? 8'h46 : 8'h42;
            2'd1:    data_out = use_fizz ? 8'h69 : 8'h75;
            default: data_out = 8'h7A;
          endcase
        end
      end
      S_EOL: begin
        valid_out = 1'b1;
`ifdef FIZZBUZZ_TX_CRLF_EN
        data_out  = idx_q[0] ? 8'h0A : 8'h0D;
`else
        data_out  = 8'h0A;
`endif
      end
      default: begin
        valid_out = 1'b0;
        data_out  = 8'h00;
      end
    endcase
  end

endmodule
`default_nettype wire
